// File: rtl/fifo_sync_param.sv
// Parametrised synchronous FIFO with registered read, programmable almost-full/empty
// thresholds, occupancy count and sticky overflow/underflow error flags.
module fifo_sync_param #(
    parameter int DATA_W = 10,
    parameter int ADDR_W = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              push,
    input  logic [DATA_W-1:0] data_in,
    input  logic              pop,
    input  logic [ADDR_W:0]   af_thresh,
    input  logic [ADDR_W:0]   ae_thresh,
    input  logic              err_clr,
    output logic [DATA_W-1:0] data_out,
    output logic              data_valid,
    output logic [ADDR_W:0]   count,
    output logic              full,
    output logic              empty,
    output logic              almost_full,
    output logic              almost_empty,
    output logic              overflow,
    output logic              underflow
);

    localparam int DEPTH = 1 << ADDR_W;
    localparam logic [ADDR_W:0] DEPTH_CNT = (ADDR_W + 1)'(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic              push_ok;
    logic              pop_ok;

    // Status flags decode the count register directly so they never lag occupancy.
    assign full         = (count == DEPTH_CNT);
    assign empty        = (count == '0);
    assign almost_full  = (count >= af_thresh);
    assign almost_empty = (count <= ae_thresh);

    // A full FIFO still accepts a push when a pop frees a slot on the same edge.
    assign pop_ok  = pop & ~empty;
    assign push_ok = push & (~full | pop_ok);

    always_ff @(posedge clk) begin
        // NOTE: the storage array is deliberately left out of reset; count and the
        // pointers define which entries are live, so stale contents are never read.
        if (push_ok) begin
            mem[wr_ptr] <= data_in;
        end

        if (reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            data_out   <= '0;
            data_valid <= 1'b0;
            overflow   <= 1'b0;
            underflow  <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments make every read below see pre-edge state,
            // so a pop of a full FIFO returns the old word even while it is overwritten.
            if (push_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end

            if (pop_ok) begin
                data_out <= mem[rd_ptr];
                rd_ptr   <= rd_ptr + 1'b1;
            end
            data_valid <= pop_ok;

            if (push_ok && !pop_ok) begin
                count <= count + 1'b1;
            end else if (pop_ok && !push_ok) begin
                count <= count - 1'b1;
            end

            // Error events take priority over a coincident clear.
            if (push && !push_ok) begin
                overflow <= 1'b1;
            end else if (err_clr) begin
                overflow <= 1'b0;
            end

            if (pop && !pop_ok) begin
                underflow <= 1'b1;
            end else if (err_clr) begin
                underflow <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_fifo_sync_param.sv
// Directed self-checking bench for fifo_sync_param (DATA_W=10, ADDR_W=3, depth 8).
module tb_fifo_sync_param;

    localparam int DATA_W = 10;
    localparam int ADDR_W = 3;

    logic              clk = 1'b0;
    logic              reset;
    logic              push;
    logic [DATA_W-1:0] data_in;
    logic              pop;
    logic [ADDR_W:0]   af_thresh;
    logic [ADDR_W:0]   ae_thresh;
    logic              err_clr;
    logic [DATA_W-1:0] data_out;
    logic              data_valid;
    logic [ADDR_W:0]   count;
    logic              full;
    logic              empty;
    logic              almost_full;
    logic              almost_empty;
    logic              overflow;
    logic              underflow;

    int checks   = 0;
    int failures = 0;

    fifo_sync_param #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
        .clk          (clk),
        .reset        (reset),
        .push         (push),
        .data_in      (data_in),
        .pop          (pop),
        .af_thresh    (af_thresh),
        .ae_thresh    (ae_thresh),
        .err_clr      (err_clr),
        .data_out     (data_out),
        .data_valid   (data_valid),
        .count        (count),
        .full         (full),
        .empty        (empty),
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
        .overflow     (overflow),
        .underflow    (underflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one clock; inputs change and outputs are sampled 1 ns after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic fill_seq();
        for (int i = 1; i <= 8; i++) begin
            push    = 1'b1;
            data_in = DATA_W'(i);
            step();
        end
        push = 1'b0;
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_count"}, 32'(count), 0);
        check({tag, "_empty"}, 32'(empty), 1);
        check({tag, "_ae"}, 32'(almost_empty), 1);
        check({tag, "_full"}, 32'(full), 0);
        check({tag, "_af"}, 32'(almost_full), 0);
        check({tag, "_dout"}, 32'(data_out), 0);
        check({tag, "_dvalid"}, 32'(data_valid), 0);
        check({tag, "_ovf"}, 32'(overflow), 0);
        check({tag, "_udf"}, 32'(underflow), 0);
    endtask

    initial begin
        reset     = 1'b1;
        push      = 1'b0;
        pop       = 1'b0;
        data_in   = '0;
        err_clr   = 1'b0;
        af_thresh = 4'd6;
        ae_thresh = 4'd2;
        #2;

        // 1. Reset then idle
        step();
        reset = 1'b0;
        step();
        check_reset_state("t1");

        // 2. Fill with 1..8, watching flags, then drain in order
        for (int i = 1; i <= 8; i++) begin
            push    = 1'b1;
            data_in = DATA_W'(i);
            step();
            check("t2_count", 32'(count), 32'(i));
            check("t2_ae", 32'(almost_empty), (i <= 2) ? 1 : 0);
            check("t2_af", 32'(almost_full), (i >= 6) ? 1 : 0);
            check("t2_full", 32'(full), (i == 8) ? 1 : 0);
        end
        push = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            pop = 1'b1;
            step();
            check("t2_dvalid", 32'(data_valid), 1);
            check("t2_dout", 32'(data_out), 32'(i));
        end
        pop = 1'b0;
        step();
        check("t2_dvalid_idle", 32'(data_valid), 0);
        check("t2_empty", 32'(empty), 1);
        check("t2_dout_hold", 32'(data_out), 8);

        // 3. Overflow: push while full is dropped
        fill_seq();
        push    = 1'b1;
        data_in = 10'h3FF;
        step();
        push = 1'b0;
        check("t3_ovf", 32'(overflow), 1);
        check("t3_count", 32'(count), 8);
        for (int i = 1; i <= 8; i++) begin
            pop = 1'b1;
            step();
            check("t3_dout", 32'(data_out), 32'(i));
        end
        pop = 1'b0;
        step();
        check("t3_empty", 32'(empty), 1);
        check("t3_ovf_sticky", 32'(overflow), 1);
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
        check("t3_ovf_clr", 32'(overflow), 0);

        // 4. Simultaneous push and pop while full
        fill_seq();
        push    = 1'b1;
        pop     = 1'b1;
        data_in = 10'h2AA;
        step();
        push = 1'b0;
        pop  = 1'b0;
        check("t4_count", 32'(count), 8);
        check("t4_dout", 32'(data_out), 1);
        check("t4_dvalid", 32'(data_valid), 1);
        check("t4_ovf", 32'(overflow), 0);
        for (int i = 2; i <= 9; i++) begin
            pop = 1'b1;
            step();
            check("t4_drain", 32'(data_out), (i == 9) ? 32'h2AA : 32'(i));
        end
        pop = 1'b0;
        step();
        check("t4_empty", 32'(empty), 1);

        // 5. Simultaneous push and pop while empty: no fall-through
        push    = 1'b1;
        pop     = 1'b1;
        data_in = 10'h155;
        step();
        push = 1'b0;
        pop  = 1'b0;
        check("t5_udf", 32'(underflow), 1);
        check("t5_count", 32'(count), 1);
        check("t5_dvalid", 32'(data_valid), 0);
        pop = 1'b1;
        step();
        pop = 1'b0;
        check("t5_dout", 32'(data_out), 32'h155);
        check("t5_dvalid2", 32'(data_valid), 1);
        err_clr = 1'b1;
        step();
        check("t5_udf_clr", 32'(underflow), 0);
        check("t5_ovf_clr", 32'(overflow), 0);
        pop = 1'b1;
        step();
        pop     = 1'b0;
        err_clr = 1'b0;
        check("t5_set_wins", 32'(underflow), 1);
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
        check("t5_udf_clr2", 32'(underflow), 0);

        // 6. Reset mid-operation, then threshold edges
        for (int i = 0; i < 4; i++) begin
            push    = 1'b1;
            data_in = DATA_W'(10'h040 + i);
            step();
        end
        push = 1'b0;
        check("t6_count4", 32'(count), 4);
        reset = 1'b1;
        step();
        reset = 1'b0;
        check_reset_state("t6");
        push    = 1'b1;
        data_in = 10'h0A0;
        step();
        push = 1'b0;
        pop  = 1'b1;
        step();
        pop = 1'b0;
        check("t6_dout", 32'(data_out), 32'h0A0);
        check("t6_empty", 32'(empty), 1);
        fill_seq();
        af_thresh = 4'd9;
        #1;
        check("t6_af_9", 32'(almost_full), 0);
        af_thresh = 4'd8;
        #1;
        check("t6_af_8", 32'(almost_full), 1);
        ae_thresh = 4'd8;
        #1;
        check("t6_ae_8", 32'(almost_empty), 1);
        ae_thresh = 4'd7;
        #1;
        check("t6_ae_7", 32'(almost_empty), 0);
        reset     = 1'b1;
        af_thresh = 4'd0;
        step();
        reset = 1'b0;
        check("t6_af_zero", 32'(almost_full), 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
